// File: rtl/ibex_cheri_cap_access_seq.sv
// ibex_cheri_cap_access_seq: checks each LSU access against the capability checker and runs it on the
// 32-bit data bus. Capability accesses become two word beats. Optional IBEX_CHERI_ACCESS_SEQ_STATS_EN adds counters. Rev 1.0
`default_nettype none

module ibex_cheri_cap_access_seq #(
  parameter int unsigned MaxWaitCycles = 0,
  parameter int unsigned CheriExcWidth = 11  // must match the core package's CheriExcWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic                     we_i,
  input  logic [31:0]              addr_i,
  input  logic [1:0]               type_i,
  input  logic [63:0]              wdata_i,
  input  logic                     wtag_i,
  output logic                     resp_valid_o,
  output logic [63:0]              resp_rdata_o,
  output logic                     resp_rtag_o,
  output logic                     resp_err_o,
  output logic                     resp_misaligned_o,
  output logic [CheriExcWidth-1:0] resp_exc_o,
  output logic [31:0]              chk_addr_o,
  output logic [1:0]               chk_type_o,
  output logic                     chk_we_o,
  input  logic [CheriExcWidth-1:0] chk_exc_i,
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  output logic [31:0]              data_addr_o,
  output logic                     data_we_o,
  output logic [3:0]               data_be_o,
  output logic [31:0]              data_wdata_o,
  output logic                     data_wtag_o,
  input  logic                     data_rvalid_i,
  input  logic                     data_err_i,
  input  logic [31:0]              data_rdata_i,
  input  logic                     data_rtag_i,
  output logic                     timeout_o
`ifdef IBEX_CHERI_ACCESS_SEQ_STATS_EN
  ,
  output logic [31:0]              stat_access_o,
  output logic [31:0]              stat_fault_o,
  output logic [31:0]              stat_split_o
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, CHECK = 3'd1, LO_REQ = 3'd2, LO_WAIT = 3'd3,
    HI_REQ = 3'd4, HI_WAIT = 3'd5, RESP = 3'd6
  } state_e;

  state_e                   state_q, state_d;
  logic                     we_q, we_d, wtag_q, wtag_d, tag_lo_q, tag_lo_d, drain_q, drain_d;
  logic [31:0]              addr_q, addr_d;
  logic [1:0]               type_q, type_d;
  logic [63:0]              wdata_q, wdata_d, rdata_q, rdata_d, hold_rdata_q;
  logic                     err_q, err_d, mis_q, mis_d, rtag_q, rtag_d;
  logic                     hold_err_q, hold_mis_q, hold_rtag_q;
  logic [CheriExcWidth-1:0] exc_q, exc_d, hold_exc_q;
  logic                     misaligned, bus_state, wd_hit, is_cap;
  logic [3:0]               be;

  assign is_cap    = (type_q == 2'b11);
  assign bus_state = (state_q == LO_REQ) || (state_q == LO_WAIT) ||
                     (state_q == HI_REQ) || (state_q == HI_WAIT);

  always_comb begin
    misaligned = 1'b0;
    case (type_i)
      2'b11:   misaligned = |addr_i[2:0];
      2'b00:   misaligned = |addr_i[1:0];
      2'b01:   misaligned = addr_i[0];
      default: misaligned = 1'b0;
    endcase
  end

  // Watchdog counts consecutive cycles in one bus state; wd_hit marks its final allowed cycle.
  if (MaxWaitCycles > 0) begin : g_wdog
    logic [31:0] wd_cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i || (state_d != state_q) || !bus_state) wd_cnt_q <= 32'd0;
      else                                             wd_cnt_q <= wd_cnt_q + 32'd1;
    end
    assign wd_hit = bus_state && (wd_cnt_q == 32'(MaxWaitCycles - 1));
  end else begin : g_no_wdog
    assign wd_hit = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    type_d     = type_q;
    wdata_d    = wdata_q;
    wtag_d     = wtag_q;
    tag_lo_d   = tag_lo_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mis_d      = mis_q;
    exc_d      = exc_q;
    rtag_d     = rtag_q;
    drain_d    = drain_q & ~data_rvalid_i;
    gnt_o      = 1'b0;
    data_req_o = 1'b0;
    timeout_o  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = ~drain_q;
        if (req_i && !drain_q) begin
          we_d    = we_i;
          addr_d  = addr_i;
          type_d  = type_i;
          wdata_d = wdata_i;
          wtag_d  = wtag_i;
          rdata_d = 64'd0;
          exc_d   = '0;
          rtag_d  = 1'b0;
          err_d   = misaligned;
          mis_d   = misaligned;
          state_d = misaligned ? RESP : CHECK;
        end
      end
      CHECK: begin
        if (|chk_exc_i) begin
          exc_d   = chk_exc_i;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = LO_REQ;
        end
      end
      LO_REQ, HI_REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          state_d = (state_q == LO_REQ) ? LO_WAIT : HI_WAIT;
        end else if (wd_hit) begin
          timeout_o = 1'b1;
          err_d     = 1'b1;
          state_d   = RESP;
        end
      end
      LO_WAIT: begin
        if (data_rvalid_i) begin
          rdata_d[31:0] = data_rdata_i;
          tag_lo_d      = data_rtag_i;
          if (data_err_i) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = is_cap ? HI_REQ : RESP;
          end
        end else if (wd_hit) begin
          timeout_o = 1'b1;
          err_d     = 1'b1;
          drain_d   = 1'b1;
          state_d   = RESP;
        end
      end
      HI_WAIT: begin
        if (data_rvalid_i) begin
          rdata_d[63:32] = data_rdata_i;
          rtag_d         = tag_lo_q & data_rtag_i & ~we_q;
          err_d          = err_q | data_err_i;
          state_d        = RESP;
        end else if (wd_hit) begin
          timeout_o = 1'b1;
          err_d     = 1'b1;
          drain_d   = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      type_q       <= 2'b00;
      wdata_q      <= 64'd0;
      wtag_q       <= 1'b0;
      tag_lo_q     <= 1'b0;
      drain_q      <= 1'b0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
      mis_q        <= 1'b0;
      exc_q        <= '0;
      rtag_q       <= 1'b0;
      hold_rdata_q <= 64'd0;
      hold_err_q   <= 1'b0;
      hold_mis_q   <= 1'b0;
      hold_exc_q   <= '0;
      hold_rtag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      type_q   <= type_d;
      wdata_q  <= wdata_d;
      wtag_q   <= wtag_d;
      tag_lo_q <= tag_lo_d;
      drain_q  <= drain_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
      exc_q    <= exc_d;
      rtag_q   <= rtag_d;
      if (state_q == RESP) begin
        hold_rdata_q <= rdata_q;
        hold_err_q   <= err_q;
        hold_mis_q   <= mis_q;
        hold_exc_q   <= exc_q;
        hold_rtag_q  <= rtag_q;
      end
    end
  end

  // Working fields change mid-access, so outside RESP the last completed response is shown.
  assign resp_valid_o      = (state_q == RESP);
  assign resp_rdata_o      = resp_valid_o ? rdata_q : hold_rdata_q;
  assign resp_err_o        = resp_valid_o ? err_q   : hold_err_q;
  assign resp_misaligned_o = resp_valid_o ? mis_q   : hold_mis_q;
  assign resp_exc_o        = resp_valid_o ? exc_q   : hold_exc_q;
  assign resp_rtag_o       = resp_valid_o ? rtag_q  : hold_rtag_q;

  assign chk_addr_o = addr_q;
  assign chk_type_o = type_q;
  assign chk_we_o   = we_q;

  always_comb begin
    be = 4'b1111;
    case (type_q)
      2'b10:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign data_addr_o  = data_req_o ? ({addr_q[31:2], 2'b00} + ((state_q == HI_REQ) ? 32'd4 : 32'd0))
                                   : 32'd0;
  assign data_we_o    = data_req_o & we_q;
  assign data_be_o    = data_req_o ? be : 4'b0000;
  assign data_wdata_o = (state_q == HI_REQ) ? wdata_q[63:32] :
                        (state_q == LO_REQ) ? wdata_q[31:0]  : 32'd0;
  assign data_wtag_o  = data_req_o & is_cap & wtag_q;

`ifdef IBEX_CHERI_ACCESS_SEQ_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_access_o <= 32'd0;
      stat_fault_o  <= 32'd0;
      stat_split_o  <= 32'd0;
    end else begin
      if (state_q == RESP)                            stat_access_o <= stat_access_o + 32'd1;
      if ((state_q == RESP) && err_q)                 stat_fault_o  <= stat_fault_o + 32'd1;
      if ((state_d == HI_REQ) && (state_q != HI_REQ)) stat_split_o  <= stat_split_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_cheri_cap_access_seq.sv
// Bench for ibex_cheri_cap_access_seq: directed accesses, a transaction-level model of the expected bus
// beats and response, and a per-cycle compare process. Rev 1.0
`default_nettype none

module tb_ibex_cheri_cap_access_seq;
  localparam int EXW = 11;
  localparam int MAXW = 4;
  localparam logic [EXW-1:0] EXC_LENGTH = 11'h001;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            req_i = 0, we_i = 0, wtag_i = 0;
  logic [31:0]     addr_i = 0;
  logic [1:0]      type_i = 0;
  logic [63:0]     wdata_i = 0;
  logic [EXW-1:0]  chk_exc_i = 0;
  logic            data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0, data_rtag_i = 0;
  logic [31:0]     data_rdata_i = 0;
  logic            gnt_o, resp_valid_o, resp_rtag_o, resp_err_o, resp_misaligned_o, chk_we_o;
  logic [63:0]     resp_rdata_o;
  logic [EXW-1:0]  resp_exc_o;
  logic [31:0]     chk_addr_o, data_addr_o, data_wdata_o;
  logic [1:0]      chk_type_o;
  logic            data_req_o, data_we_o, data_wtag_o, timeout_o;
  logic [3:0]      data_be_o;
`ifdef IBEX_CHERI_ACCESS_SEQ_STATS_EN
  logic [31:0]     stat_access, stat_fault, stat_split;
`endif

  ibex_cheri_cap_access_seq #(.MaxWaitCycles(MAXW), .CheriExcWidth(EXW)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i),
    .type_i(type_i), .wdata_i(wdata_i), .wtag_i(wtag_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_rtag_o(resp_rtag_o), .resp_err_o(resp_err_o),
    .resp_misaligned_o(resp_misaligned_o), .resp_exc_o(resp_exc_o), .chk_addr_o(chk_addr_o),
    .chk_type_o(chk_type_o), .chk_we_o(chk_we_o), .chk_exc_i(chk_exc_i), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_wtag_o(data_wtag_o), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_rdata_i(data_rdata_i), .data_rtag_i(data_rtag_i),
    .timeout_o(timeout_o)
`ifdef IBEX_CHERI_ACCESS_SEQ_STATS_EN
    , .stat_access_o(stat_access), .stat_fault_o(stat_fault), .stat_split_o(stat_split)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model state: expected bus beats and response of the access in flight, and the last response.
  int             exp_nb, exp_lat;
  logic [31:0]    exp_baddr[2], exp_bwd[2];
  logic [3:0]     exp_bbe[2];
  logic           exp_bwt[2], exp_bwe;
  logic [63:0]    exp_rdata, held_rdata = 0;
  logic           exp_rtag, exp_err, exp_mis, held_rtag = 0, held_err = 0, held_mis = 0;
  logic [EXW-1:0] exp_exc, held_exc = 0;
  logic [31:0]    cur_addr;
  logic [1:0]     cur_type;
  logic           cur_we;
  logic           resp_pending = 0, accepted = 0;
  int             beat_idx = 0;

  task automatic model(input logic we, input logic [31:0] a, input logic [1:0] t, input logic [63:0] wd,
                       input logic wt, input logic [EXW-1:0] exc, input logic [31:0] rlo, rhi,
                       input logic glo, ghi, elo, ehi, hang);
    bit cap;
    cap     = (t == 2'b11);
    exp_mis = (t == 2'b11) ? (a % 8 != 0) : (t == 2'b00) ? (a % 4 != 0) : (t == 2'b01) ? (a % 2 != 0) : 1'b0;
    if (exp_mis || exc != 0) exp_nb = 0;
    else if (!cap || hang || elo) exp_nb = 1;
    else exp_nb = 2;
    for (int i = 0; i < 2; i++) begin
      exp_baddr[i] = (a & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_bbe[i]   = (cap || t == 2'b00) ? 4'hF : (t == 2'b01) ? ((a & 2) != 0 ? 4'hC : 4'h3)
                                                               : 4'(1 << (a & 3));
      exp_bwd[i]   = (cap && i == 1) ? wd[63:32] : wd[31:0];
      exp_bwt[i]   = cap && wt;
    end
    exp_bwe   = we;
    exp_exc   = exp_mis ? '0 : exc;
    exp_rdata = 64'd0;
    if (exp_nb >= 1 && !hang) exp_rdata[31:0] = rlo;
    if (exp_nb == 2) exp_rdata[63:32] = rhi;
    exp_rtag = cap && !we && exp_nb == 2 && glo && ghi;
    exp_err  = exp_mis || exc != 0 || hang || (exp_nb >= 1 && elo) || (exp_nb == 2 && ehi);
    exp_lat  = exp_mis ? 1 : (exc != 0) ? 2 : hang ? 2 + 1 + MAXW : 2 + 2 * exp_nb;
    cur_addr = a; cur_type = t; cur_we = we;
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (data_req_o) begin
        if (beat_idx < exp_nb) begin
          chk("beat_addr", data_addr_o, exp_baddr[beat_idx]);
          chk("beat_be", data_be_o, exp_bbe[beat_idx]);
          chk("beat_we", data_we_o, exp_bwe);
          chk("beat_wdata", data_wdata_o, exp_bwd[beat_idx]);
          chk("beat_wtag", data_wtag_o, exp_bwt[beat_idx]);
        end else chk("unexpected_req", 1, 0);
        if (data_gnt_i) beat_idx++;
      end
      if (accepted && resp_pending) begin
        chk("chk_addr", chk_addr_o, cur_addr);
        chk("chk_type", chk_type_o, cur_type);
        chk("chk_we", chk_we_o, cur_we);
      end
      if (resp_valid_o) begin
        if (resp_pending) begin
          held_rdata = exp_rdata; held_err = exp_err; held_mis = exp_mis;
          held_exc = exp_exc; held_rtag = exp_rtag;
          resp_pending = 0;
        end else chk("unexpected_resp", 1, 0);
      end
      chk("resp_rdata", resp_rdata_o, held_rdata);
      chk("resp_err", resp_err_o, held_err);
      chk("resp_mis", resp_misaligned_o, held_mis);
      chk("resp_exc", resp_exc_o, held_exc);
      chk("resp_rtag", resp_rtag_o, held_rtag);
    end
  end

  int          n0, first_req, resp_cyc, to_cyc, obs_n;
  logic [31:0] obs_addr[2], obs_wd[2];
  logic [3:0]  obs_be[2];
  logic        obs_wt[2];

  // Runs one access; the bench grants in the request cycle and answers the cycle after.
  task automatic do_access(input logic we, input logic [31:0] a, input logic [1:0] t, input logic [63:0] wd,
                           input logic wt, input logic [EXW-1:0] exc, input logic [31:0] rlo, rhi,
                           input logic glo, ghi, elo, ehi, hang);
    bit pend = 0;
    int brv = 0;
    model(we, a, t, wd, wt, exc, rlo, rhi, glo, ghi, elo, ehi, hang);
    accepted = 0; beat_idx = 0; resp_pending = 1;
    first_req = -1; resp_cyc = -1; to_cyc = -1; obs_n = 0;
    req_i = 1; we_i = we; addr_i = a; type_i = t; wdata_i = wd; wtag_i = wt; chk_exc_i = exc;
    n0 = cyc;
    chk("gnt_idle", gnt_o, 1);
    @(posedge clk); #1;
    req_i = 0; accepted = 1;
    for (int k = 0; k < 20 && resp_cyc < 0; k++) begin
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0; data_rtag_i = 0;
      if (pend) begin
        data_rvalid_i = 1;
        data_rdata_i  = brv ? rhi : rlo;
        data_rtag_i   = brv ? ghi : glo;
        data_err_i    = brv ? ehi : elo;
        pend = 0;
      end
      if (data_req_o) begin
        if (first_req < 0) first_req = cyc;
        data_gnt_i = 1;
        if (obs_n < 2) begin
          obs_addr[obs_n] = data_addr_o; obs_wd[obs_n] = data_wdata_o;
          obs_be[obs_n] = data_be_o; obs_wt[obs_n] = data_wtag_o;
        end
        pend = !hang; brv = obs_n; obs_n++;
      end
      if (resp_valid_o) resp_cyc = cyc;
      if (timeout_o) to_cyc = cyc;
      @(posedge clk); #1;
    end
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0; data_rtag_i = 0; chk_exc_i = 0;
    if (resp_cyc < 0) begin
      chk("resp_never_came", 0, 1);
      resp_pending = 0;
    end
    accepted = 0;
    chk("lat_first_req", first_req, (exp_nb == 0) ? -1 : n0 + 2);
    chk("lat_resp", resp_cyc, n0 + exp_lat);
    chk("timeout_cyc", to_cyc, hang ? n0 + 2 + MAXW : -1);
    chk("beat_count", obs_n, exp_nb);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_req", data_req_o, 0);
    chk("rst_be", data_be_o, 0);
    chk("rst_chk_addr", chk_addr_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    rst_i = 0;
    @(posedge clk); #1;

    // word load
    do_access(0, 32'h1000, 2'b00, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    chk("lit_word_rdata", held_rdata, 64'h0000_0000_DEAD_BEEF);
    chk("lit_word_req_lat", first_req - n0, 2);
    // cap store
    do_access(1, 32'h2008, 2'b11, 64'h1111_2222_3333_4444, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_cs_a0", obs_addr[0], 32'h2008);
    chk("lit_cs_d0", obs_wd[0], 32'h3333_4444);
    chk("lit_cs_a1", obs_addr[1], 32'h200C);
    chk("lit_cs_d1", obs_wd[1], 32'h1111_2222);
    chk("lit_cs_t", {obs_wt[0], obs_wt[1]}, 2'b11);
    // cap loads: mixed tags, both tags, error on low half
    do_access(0, 32'h2010, 2'b11, 0, 0, 0, 32'hAAAA_0001, 32'hBBBB_0002, 1, 0, 0, 0, 0);
    chk("lit_cl_rdata", held_rdata, 64'hBBBB_0002_AAAA_0001);
    chk("lit_cl_tag0", held_rtag, 0);
    do_access(0, 32'h2018, 2'b11, 0, 0, 0, 32'h5, 32'h6, 1, 1, 0, 0, 0);
    chk("lit_cl_tag1", held_rtag, 1);
    do_access(0, 32'h2020, 2'b11, 0, 0, 0, 32'h7, 32'h8, 1, 1, 1, 0, 0);
    chk("lit_cl_loerr_beats", obs_n, 1);
    do_access(0, 32'h2028, 2'b11, 0, 0, 0, 32'h9, 32'hA, 1, 1, 0, 1, 0);
    // checker fault, misalignment, lane enables
    do_access(0, 32'h3003, 2'b10, 0, 0, EXC_LENGTH, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_exc_val", held_exc, 11'h001);
    do_access(0, 32'h4001, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_mis_lat", resp_cyc - n0, 1);
    do_access(0, 32'h2004, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_access(0, 32'h4002, 2'b01, 0, 0, 0, 32'hCAFE_0000, 0, 0, 0, 0, 0, 0);
    chk("lit_be_hi_half", obs_be[0], 4'hC);
    do_access(1, 32'h5001, 2'b10, 64'h0000_AB00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_be_byte1", obs_be[0], 4'h2);
    do_access(1, 32'h4000, 2'b01, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_be_lo_half", obs_be[0], 4'h3);
    do_access(1, 32'h6000, 2'b00, 64'h5555_AAAA, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // watchdog expiry in LO_WAIT, then drain of the late response
    do_access(0, 32'h7000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_to_wait", to_cyc - n0, 6);
    chk("drain_gnt0_a", gnt_o, 0);
    @(posedge clk); #1;
    chk("drain_gnt0_b", gnt_o, 0);
    data_rvalid_i = 1; data_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    data_rvalid_i = 0; data_rdata_i = 0;
    chk("drain_gnt1", gnt_o, 1);
    repeat (3) @(posedge clk);
    #1;

    // reset while the low beat is still being requested
    model(0, 32'h8000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    beat_idx = 0; resp_pending = 1; accepted = 0;
    req_i = 1; we_i = 0; addr_i = 32'h8000; type_i = 2'b00;
    @(posedge clk); #1;
    req_i = 0; accepted = 1;
    @(posedge clk); #1;
    chk("rst_mid_req", data_req_o, 1);
    rst_i = 1; resp_pending = 0; accepted = 0;
    @(posedge clk); #1;
    rst_i = 0;
    held_rdata = 0; held_err = 0; held_mis = 0; held_exc = 0; held_rtag = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_gnt", gnt_o, 1);
    chk("rst_mid_noreq", data_req_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ibex_cheri_cap_access_seq.md
Name: ibex_cheri_cap_access_seq

Overview:
Sequences every load/store from the CHERI LSU onto the 32-bit data bus. Each access is first run through the combinational capability memory checker, which evaluates it against the authorising capability. Capability-width accesses (64-bit + tag) are split into two word transactions. Responses are merged back into one response with error/exception status. It sits between the LSU and the data-bus port, owning the checker's address/type/we inputs.

Parameters:
MaxWaitCycles, 0, bus watchdog limit in cycles per REQ/WAIT state; 0 disables the watchdog
CheriExcWidth, ibex_pkg::CheriExcWidth, width of the CHERI exception vector

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  1  LSU access request
gnt_o  out  1  request accepted this cycle
we_i  in  1  store when 1
addr_i  in  32  byte address
type_i  in  2  00 word, 01 half, 10 byte, 11 capability (8 bytes + tag)
wdata_i  in  64  store data, byte lanes pre-aligned; [63:32] used only for type 11
wtag_i  in  1  store tag (type 11 only)
resp_valid_o  out  1  one-cycle response strobe
resp_rdata_o  out  64  load data; non-cap: raw word in [31:0], [63:32]=0
resp_rtag_o  out  1  loaded tag
resp_err_o  out  1  any failure: bus error, CHERI fault, misaligned, or timeout
resp_misaligned_o  out  1  alignment fault
resp_exc_o  out  CheriExcWidth  latched checker exceptions
chk_addr_o  out  32  address presented to checker
chk_type_o  out  2  type presented to checker
chk_we_o  out  1  we presented to checker
chk_exc_i  in  CheriExcWidth  combinational checker result
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned bus address
data_we_o  out  1  bus write
data_be_o  out  4  byte enables
data_wdata_o  out  32  bus write data
data_wtag_o  out  1  bus write tag
data_rvalid_i  in  1  bus response valid
data_err_i  in  1  bus error
data_rdata_i  in  32  bus read data
data_rtag_i  in  1  bus read tag
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- States: IDLE, CHECK, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, RESP.
- Reset: state IDLE. All outputs 0 except gnt_o=1. Drain flag 0; watchdog 0. Reset mid-transaction abandons it with no response.
- IDLE: gnt_o = ~drain. On req_i & gnt_o, latch we, addr, type, wdata, wtag, then go to CHECK.
- Misalignment check in IDLE on accept:
  - type 11 requires addr[2:0]=0.
  - type 00 requires addr[1:0]=0.
  - type 01 requires addr[0]=0.
  - On failure go to RESP with err=1 and misaligned=1; no checker evaluation, no bus activity.
- CHECK: chk_* driven from latched values (chk_* = latched values in all states; 0 after reset).
  - If chk_exc_i != 0, latch it into resp_exc_o and go to RESP with err=1.
  - Otherwise go to LO_REQ.
- Latency: accept in cycle N, CHECK in N+1, earliest data_req_o in N+2.
- LO_REQ / HI_REQ: data_req_o=1.
  - data_addr_o = {addr[31:2],2'b00}; HI uses +4.
  - addr, we, be, wdata and wtag are held stable until data_gnt_i.
  - Non-cap byte enables:
    - byte: 1<<addr[1:0]
    - half: 0011 or 1100
    - word: 1111
  - Cap: be=1111 for both halves. LO uses wdata[31:0], HI uses wdata[63:32]; data_wtag_o=wtag on both halves.
  - On data_gnt_i go to the matching WAIT state.
- One outstanding transaction only.
- LO_WAIT: on data_rvalid_i capture rdata into [31:0] and rtag into tag_lo.
  - data_err_i: go to RESP with err=1, skipping HI.
  - Else if type 11: go to HI_REQ.
  - Else: go to RESP.
- HI_WAIT: on data_rvalid_i capture [63:32] and set resp_rtag_o = tag_lo & data_rtag_i; data_err_i sets err. Go to RESP.
- resp_rtag_o = 0 for non-cap accesses and for all stores.
- RESP: resp_valid_o=1 for exactly one cycle with data/err stable; go to IDLE. Response fields hold until the next RESP.
- Watchdog (MaxWaitCycles>0):
  - Counter clears on every state change and counts while in a REQ/WAIT state.
  - On reaching MaxWaitCycles: timeout_o pulse, go to RESP with err=1.
  - If expiry occurs in a WAIT state, set drain.
  - While drain=1, the next data_rvalid_i is discarded and clears drain; gnt_o=0 while drain=1.
  - Expiry in a REQ state drops data_req_o with no drain.
  - data_rvalid_i in the same cycle as expiry counts as normal completion; there is no timeout.
- data_rvalid_i outside WAIT states with drain=0 is ignored.

Optional Feature:
IBEX_CHERI_ACCESS_SEQ_STATS_EN.
- Defined: adds outputs stat_access_o[31:0] (increments at each RESP), stat_fault_o[31:0] (increments at RESP with err=1), and stat_split_o[31:0] (increments at each HI_REQ entry).
- All three are cleared by rst_i and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Word load addr 0x1000, chk_exc_i=0, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF -> data_req_o in N+2, be=1111, resp_rdata_o=0x00000000DEADBEEF, err=0.
- Cap store addr 0x2008, wdata=0x11112222_33334444, wtag=1 -> two bus writes: 0x2008/0x33334444 then 0x200C/0x11112222, wtag=1 both; one resp_valid_o.
- Cap load, rtag 1 then 0 -> resp_rtag_o=0. Cap load with data_err_i on LO -> no HI request, resp_err_o=1.
- Byte load addr 0x3003 with chk_exc_i LENGTH bit set -> no data_req_o, resp_exc_o has only that bit, err=1, resp in N+2.
- Half load addr 0x4001 -> resp_misaligned_o=1 in N+1, no chk evaluation, no bus activity.
- MaxWaitCycles=4, gnt then no rvalid -> timeout_o after 4 WAIT cycles, resp err=1, gnt_o=0 until late rvalid, which produces no response.
